program_memory: RTL and testbench
=================================

PROGRAM_MEMORY -- requirements
Module: program_memory

Interface
REQ-001 SHALL have parameter FILL, default 8'h00: the byte driven on instruction for unloaded addresses and outside RUN.
REQ-002 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port load_start  in  1  a one-cycle request to begin (re)loading a program.
REQ-005 SHALL have port load_valid  in  1  load_data is valid this cycle.
REQ-006 SHALL have port load_data  in  8  a program byte (or checksum byte).
REQ-007 SHALL have port load_last  in  1  qualifies the current byte as the final program byte.
REQ-008 SHALL have port load_ready  out  1  the block accepts a byte this cycle.
REQ-009 SHALL have port PC  in  8  the processor fetch address.
REQ-010 SHALL have port instruction  out  8  the registered fetched instruction.
REQ-011 SHALL have port run  out  1  high while in RUN.
REQ-012 SHALL have port prog_len  out  9  the number of program bytes loaded, 0..256.
REQ-013 SHALL have port error  out  1  the last load failed its checksum.

Function
REQ-014 SHALL implement a 256x8 program RAM with states IDLE, LOAD, RUN, plus CHK when REQ-031 applies.
REQ-015 IDLE: load_ready=0; load_start -> LOAD with write address 0, prog_len 0 and error 0.
REQ-016 LOAD: load_ready=1; a byte transfers only when load_valid & load_ready are both high in the same cycle.
REQ-017 On each transfer, SHALL write mem[addr] <= load_data and increment addr and prog_len.
REQ-018 A transfer with load_last=1 SHALL end the program: go to RUN, or to CHK when checksumming is enabled.
REQ-019 The 256th transfer SHALL end the program even when load_last=0; addr SHALL never wrap to overwrite byte 0.
REQ-020 load_valid with load_ready=0 SHALL be ignored, with no write and no counter change.
REQ-021 load_start during LOAD or CHK SHALL be ignored.
REQ-022 load_start during RUN SHALL go to LOAD and clear prog_len; RAM contents are not cleared.
REQ-023 load_start and load_valid together in IDLE or RUN SHALL not transfer a byte; the byte is accepted from the following cycle.
REQ-024 RUN: the instruction register SHALL load mem[PC] when PC < prog_len, else FILL, giving 1-cycle latency from PC to instruction.
REQ-025 Outside RUN, the instruction register SHALL load FILL each cycle.
REQ-026 run SHALL be registered and equal 1 exactly in the cycles the state is RUN.
REQ-027 prog_len arithmetic SHALL be 9-bit unsigned; the PC comparison SHALL zero-extend PC to 9 bits.

Reset
REQ-028 reset SHALL asynchronously force state=IDLE, addr=0, prog_len=0, instruction=FILL, run=0, load_ready=0, error=0, and the checksum accumulator to 0.
REQ-029 reset mid-LOAD SHALL abandon the load; after release the block sits in IDLE with run=0 until load_start.
REQ-030 RAM contents SHALL not be reset.

Configuration
REQ-031 With macro PROG_CHECKSUM_EN defined: a sum8 accumulator (mod 256) SHALL sum the program bytes; in CHK, load_ready=1 and the next transfer is a checksum byte that is not stored. Match -> RUN with error=0; mismatch -> IDLE with error=1 and prog_len=0. error SHALL stay set until the next load_start or reset.
REQ-032 Without PROG_CHECKSUM_EN: there SHALL be no CHK state and no accumulator, error SHALL be tied to 0, and REQ-018 goes directly to RUN.

Verification
REQ-033 Reset, then release; PC sweeps 0..255 -> instruction=8'h00, run=0, load_ready=0, prog_len=0.
REQ-034 load_start, then bytes 8'h11, 8'h22, 8'h3C (last) with gaps in load_valid -> run=1 and prog_len=3. PC=0, 1, 2, 3 -> instruction 8'h11, 8'h22, 8'h3C, 8'h00, each one cycle after the PC changes.
REQ-035 load_start, then 256 bytes of value i with load_last=0 throughout -> RUN after the 256th transfer with prog_len=256; PC=8'hFF -> instruction 8'hFF; mem[0]=8'h00 intact.
REQ-036 Assert reset after 2 of 4 bytes -> IDLE, run=0, prog_len=0, instruction=FILL; a following load_start with 1 byte 8'hA5 (last) -> RUN with prog_len=1.
REQ-037 With PROG_CHECKSUM_EN: load 8'h01, 8'h02 (last), then checksum 8'h03 -> RUN with error=0. Repeat with checksum 8'h04 -> IDLE, error=1, prog_len=0, and instruction held at FILL.
REQ-038 In RUN, load_start together with load_valid -> LOAD with no byte accepted that cycle; run drops the next cycle.

Source files
------------

// File: rtl/program_memory.sv
// 256x8 program RAM loaded over a valid/ready byte stream, fetched by PC with one-cycle registered latency.
// Optional PROG_CHECKSUM_EN adds a trailing sum8 checksum byte (CHK state) that gates entry to RUN.
module program_memory #(
  parameter logic [7:0] FILL = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_start,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  input  logic       load_last,
  output logic       load_ready,
  input  logic [7:0] PC,
  output logic [7:0] instruction,
  output logic       run,
  output logic [8:0] prog_len,
  output logic       error
);

`ifdef PROG_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD, RUN, CHK} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
`endif

  state_t      state, next_state;
  logic [7:0]  addr;
  logic [7:0]  mem [256];
  logic        xfer;
  logic        start_ok;
  logic        end_prog;
  logic        chk_fail;

`ifdef PROG_CHECKSUM_EN
  logic [7:0] sum;
`endif

  assign start_ok = load_start && (state == IDLE || state == RUN);
  assign xfer     = load_valid && load_ready;
  // The 256th byte closes the program even without load_last.
  assign end_prog = (state == LOAD) && xfer && (load_last || prog_len == 9'd255);

  always_comb begin
    next_state = state;
    load_ready = 1'b0;
    chk_fail   = 1'b0;
    case (state)
      IDLE: if (load_start) next_state = LOAD;
      LOAD: begin
        load_ready = 1'b1;
        if (end_prog) begin
`ifdef PROG_CHECKSUM_EN
          next_state = CHK;
`else
          next_state = RUN;
`endif
        end
      end
      RUN: if (load_start) next_state = LOAD;
`ifdef PROG_CHECKSUM_EN
      CHK: begin
        load_ready = 1'b1;
        if (xfer) begin
          chk_fail   = (load_data != sum);
          next_state = chk_fail ? IDLE : RUN;
        end
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      addr        <= 8'd0;
      prog_len    <= 9'd0;
      instruction <= FILL;
      run         <= 1'b0;
    end else begin
      state <= next_state;
      run   <= (next_state == RUN);
      if (state == RUN && {1'b0, PC} < prog_len)
        instruction <= mem[PC];
      else
        instruction <= FILL;

      if (start_ok) begin
        addr     <= 8'd0;
        prog_len <= 9'd0;
      end else if (state == LOAD && xfer) begin
        prog_len <= prog_len + 9'd1;
        if (addr != 8'hFF) addr <= addr + 8'd1;
      end else if (chk_fail) begin
        prog_len <= 9'd0;
      end
    end
  end

  // RAM contents survive reset and reloads.
  always_ff @(posedge clk) begin
    if (state == LOAD && xfer) mem[addr] <= load_data;
  end

`ifdef PROG_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum   <= 8'd0;
      error <= 1'b0;
    end else if (start_ok) begin
      sum   <= 8'd0;
      error <= 1'b0;
    end else if (state == LOAD && xfer) begin
      sum <= sum + load_data;
    end else if (state == CHK && xfer) begin
      error <= chk_fail;
    end
  end
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_program_memory.sv
// Bench for program_memory: PC fetch vectors checked through an expected-value queue,
// plus hand sequences for full-length load, reset mid-load, restart from RUN and checksum.
module tb_program_memory;
  localparam logic [7:0] FILL = 8'h00;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_start;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;
  logic       load_ready;
  logic [7:0] PC;
  logic [7:0] instruction;
  logic       run;
  logic [8:0] prog_len;
  logic       error;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] sb_q [$];

  typedef struct {
    logic [7:0] pc;
    logic [7:0] exp;
  } vec_t;

  vec_t t3 [5];
  vec_t tfull [4];
  vec_t trestart [3];

  program_memory #(.FILL(FILL)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .PC(PC), .instruction(instruction), .run(run), .prog_len(prog_len), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  // Holds load_valid until a handshake completes, then idles for gap cycles.
  task automatic send(input logic [7:0] d, input logic last, input int gap);
    int w;
    load_data  = d;
    load_last  = last;
    load_valid = 1'b1;
    w = 0;
    while (!load_ready && w < 20) begin
      tick();
      w++;
    end
    if (!load_ready) check("ready_timeout", 32'(load_ready), 32'd1);
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic pc_check(input string name, input logic [7:0] pc, input logic [7:0] exp);
    logic [7:0] want;
    PC = pc;
    sb_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    want = sb_q.pop_front();
    check(name, 32'(instruction), 32'(want));
  endtask

  initial begin
    t3[0] = '{8'h00, 8'h11};
    t3[1] = '{8'h01, 8'h22};
    t3[2] = '{8'h02, 8'h3C};
    t3[3] = '{8'h03, FILL};
    t3[4] = '{8'hFF, FILL};
    tfull[0] = '{8'hFF, 8'hFF};
    tfull[1] = '{8'h00, 8'h00};
    tfull[2] = '{8'h80, 8'h80};
    tfull[3] = '{8'h01, 8'h01};
    trestart[0] = '{8'h00, 8'h5A};
    trestart[1] = '{8'h01, FILL};
    trestart[2] = '{8'hFF, FILL};

    reset = 1'b1; load_start = 1'b0; load_valid = 1'b0;
    load_data = 8'h00; load_last = 1'b0; PC = 8'h00;

    // Reset state
    sample();
    check("rst_instr", 32'(instruction), 32'(FILL));
    check("rst_run", 32'(run), 32'd0);
    check("rst_ready", 32'(load_ready), 32'd0);
    check("rst_len", 32'(prog_len), 32'd0);
    check("rst_err", 32'(error), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    for (int i = 0; i < 256; i++) pc_check("idle_sweep", 8'(i), FILL);
    check("idle_run", 32'(run), 32'd0);
    check("idle_ready", 32'(load_ready), 32'd0);
    check("idle_len", 32'(prog_len), 32'd0);

    // Three-byte program with gaps in load_valid
    pulse_start();
    sample();
    check("load_ready", 32'(load_ready), 32'd1);
    check("load_run", 32'(run), 32'd0);
    tick();
    send(8'h11, 1'b0, 2);
    send(8'h22, 1'b0, 1);
    send(8'h3C, 1'b1, 0);
    sample();
    check("p3_run", 32'(run), 32'd1);
    check("p3_len", 32'(prog_len), 32'd3);
    check("p3_ready", 32'(load_ready), 32'd0);
    for (int i = 0; i < 5; i++) pc_check("p3_fetch", t3[i].pc, t3[i].exp);

    // Full 256-byte program without load_last
    pulse_start();
    for (int i = 0; i < 255; i++) send(8'(i), 1'b0, 0);
    sample();
    check("p256_len255", 32'(prog_len), 32'd255);
    check("p256_still_load", 32'(load_ready), 32'd1);
    tick();
    send(8'hFF, 1'b0, 0);
    sample();
    check("p256_run", 32'(run), 32'd1);
    check("p256_len", 32'(prog_len), 32'd256);
    for (int i = 0; i < 4; i++) pc_check("p256_fetch", tfull[i].pc, tfull[i].exp);

    // load_start with load_valid in RUN: no byte taken that cycle
    tick();
    load_start = 1'b1; load_valid = 1'b1; load_data = 8'h77; load_last = 1'b1;
    tick();
    load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    sample();
    check("restart_run", 32'(run), 32'd0);
    check("restart_len", 32'(prog_len), 32'd0);
    check("restart_ready", 32'(load_ready), 32'd1);
    tick();
    send(8'h5A, 1'b1, 0);
    sample();
    check("restart_run2", 32'(run), 32'd1);
    check("restart_len2", 32'(prog_len), 32'd1);
    for (int i = 0; i < 3; i++) pc_check("restart_fetch", trestart[i].pc, trestart[i].exp);

    // Reset mid-load, with an ignored load_start during LOAD
    tick();
    pulse_start();
    send(8'hC1, 1'b0, 0);
    pulse_start();
    sample();
    check("ign_start_len", 32'(prog_len), 32'd1);
    check("ign_start_ready", 32'(load_ready), 32'd1);
    tick();
    send(8'hC2, 1'b0, 0);
    reset = 1'b1;
    #1;
    check("mid_rst_run", 32'(run), 32'd0);
    check("mid_rst_len", 32'(prog_len), 32'd0);
    check("mid_rst_instr", 32'(instruction), 32'(FILL));
    check("mid_rst_ready", 32'(load_ready), 32'd0);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    sample();
    check("post_rst_run", 32'(run), 32'd0);
    check("post_rst_ready", 32'(load_ready), 32'd0);
    tick();
    pulse_start();
    send(8'hA5, 1'b1, 0);
    sample();
    check("a5_run", 32'(run), 32'd1);
    check("a5_len", 32'(prog_len), 32'd1);
    pc_check("a5_fetch", 8'h00, 8'hA5);
    pc_check("a5_beyond", 8'h01, FILL);

`ifdef PROG_CHECKSUM_EN
    tick();
    pulse_start();
    send(8'h01, 1'b0, 0);
    send(8'h02, 1'b1, 0);
    sample();
    check("chk_wait_run", 32'(run), 32'd0);
    check("chk_wait_ready", 32'(load_ready), 32'd1);
    tick();
    send(8'h03, 1'b0, 0);
    sample();
    check("chk_ok_run", 32'(run), 32'd1);
    check("chk_ok_err", 32'(error), 32'd0);
    check("chk_ok_len", 32'(prog_len), 32'd2);
    pc_check("chk_ok_fetch", 8'h01, 8'h02);
    tick();
    pulse_start();
    send(8'h01, 1'b0, 0);
    send(8'h02, 1'b1, 0);
    send(8'h04, 1'b0, 0);
    sample();
    check("chk_bad_run", 32'(run), 32'd0);
    check("chk_bad_err", 32'(error), 32'd1);
    check("chk_bad_len", 32'(prog_len), 32'd0);
    check("chk_bad_ready", 32'(load_ready), 32'd0);
    pc_check("chk_bad_fetch", 8'h00, FILL);
    repeat (3) tick();
    sample();
    check("chk_err_hold", 32'(error), 32'd1);
    tick();
    pulse_start();
    sample();
    check("chk_err_clear", 32'(error), 32'd0);
`else
    check("no_chk_err", 32'(error), 32'd0);
`endif

    if (sb_q.size() != 0) check("sb_leftover", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
